// File: rtl/sqrt_arb_pkg.sv
// Shared definitions for the two-requester arbiter in front of the shared sqrt pipeline.
package sqrt_arb_pkg;

  localparam int SQRT_LAT_DEF = 5;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  // One slot of the ownership pipe that runs alongside the sqrt datapath.
  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/sqrt_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_grant moves only when a grant is issued.
module rr_arb2
  import sqrt_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic elig0,
  input  logic elig1,
  output logic gnt_valid,
  output logic gnt_id
);

  logic last_grant;

  // Eligibility already includes valid, so any grant is a transfer.
  always_comb begin
    gnt_valid = elig0 | elig1;
    gnt_id    = ID_REQ0;
    if (elig0 && elig1) begin
      gnt_id = ~last_grant;
    end else if (elig1) begin
      gnt_id = ID_REQ1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_REQ1;
    end else if (gnt_valid) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Arbitrates two requesters onto one valid-less sqrt pipeline and routes each result back to its owner.
// Handshake: a request transfers in the cycle where reqi_valid && reqi_ready; responses cannot be stalled.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SQRT_LAT   = SQRT_LAT_DEF,
  parameter int MAX_OUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_gx,
  input  logic [DATA_WIDTH-1:0] req0_gy,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_mag,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_gx,
  input  logic [DATA_WIDTH-1:0] req1_gy,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_mag,
  output logic [DATA_WIDTH-1:0] sq_in1,
  output logic [DATA_WIDTH-1:0] sq_in2,
  input  logic [DATA_WIDTH-1:0] sq_out
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0]    cnt0, cnt1;
  logic             elig0, elig1;
  logic             gnt_valid, gnt_id;
  logic             xfer0, xfer1, ret0, ret1;
  logic [TAG_W-1:0] tag_q [SQRT_LAT];
  tag_t             retire;

  assign elig0 = req0_valid && (cnt0 < CW'(MAX_OUT));
  assign elig1 = req1_valid && (cnt1 < CW'(MAX_OUT));

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .elig0     (elig0),
    .elig1     (elig1),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign req0_ready = gnt_valid && (gnt_id == ID_REQ0);
  assign req1_ready = gnt_valid && (gnt_id == ID_REQ1);
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;

  // Bubbles feed zeros so the sqrt never sees stale operands.
  always_comb begin
    sq_in1 = '0;
    sq_in2 = '0;
    if (xfer0) begin
      sq_in1 = req0_gx;
      sq_in2 = req0_gy;
    end else if (xfer1) begin
      sq_in1 = req1_gx;
      sq_in2 = req1_gy;
    end
  end

  assign retire = tag_t'(tag_q[SQRT_LAT-1]);
  assign ret0   = retire.v && (retire.id == ID_REQ0);
  assign ret1   = retire.v && (retire.id == ID_REQ1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SQRT_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= {gnt_valid, gnt_valid ? gnt_id : ID_REQ0};
      for (int i = 1; i < SQRT_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // A transfer and a retire in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      case ({xfer0, ret0})
        2'b10:   cnt0 <= cnt0 + CW'(1);
        2'b01:   cnt0 <= cnt0 - CW'(1);
        default: cnt0 <= cnt0;
      endcase
      case ({xfer1, ret1})
        2'b10:   cnt1 <= cnt1 + CW'(1);
        2'b01:   cnt1 <= cnt1 - CW'(1);
        default: cnt1 <= cnt1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_mag   <= '0;
      rsp1_mag   <= '0;
    end else begin
      rsp0_valid <= ret0;
      rsp1_valid <= ret1;
      if (ret0) rsp0_mag <= sq_out;
      if (ret1) rsp1_mag <= sq_out;
    end
  end

  a_rsp_excl: assert property (@(posedge clk) disable iff (rst) !(rsp0_valid && rsp1_valid));
  a_rdy_excl: assert property (@(posedge clk) disable iff (rst) !(req0_ready && req1_ready));
  a_cnt_max:  assert property (@(posedge clk) disable iff (rst)
                               (cnt0 <= CW'(MAX_OUT)) && (cnt1 <= CW'(MAX_OUT)));

endmodule
